brauns_array_multiplier_4bit: RTL and testbench

- Unsigned WIDTH x WIDTH multiplier built as a Braun array: AND partial-product matrix, carry-save adder rows, and a final ripple-carry row.
- The product is registered: one clock of latency, with a valid flag travelling alongside it.
- Used as a small arithmetic leaf in datapaths; default is 4x4 producing an 8-bit product.

---
 rtl/brauns_array_multiplier_4bit_full_adder_cell.sv | 14 +
 rtl/brauns_array_multiplier_4bit.sv | 105 ++++++++++
 tb/tb_brauns_array_multiplier_4bit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/brauns_array_multiplier_4bit_full_adder_cell.sv
// One-bit full adder: the single cell type of the Braun array.
// Used in both the carry-save rows and the final ripple row.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/brauns_array_multiplier_4bit.sv
// Unsigned WIDTH x WIDTH Braun array multiplier with a registered product.
// Partial products feed WIDTH-1 carry-save rows closed by a WIDTH-1 bit ripple adder.
module brauns_array_multiplier_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 in_valid,
    output logic [2*WIDTH-1:0]   AB,
    output logic                 out_valid
);

    logic [WIDTH-1:0]   pp      [WIDTH];
    logic [WIDTH-2:0]   csa_sum [1:WIDTH-1];
    logic [WIDTH-2:0]   csa_cry [1:WIDTH-1];
    logic [WIDTH-1:0]   rip_cry;
    logic [2*WIDTH-1:0] product;

    logic [2*WIDTH-1:0] ab_reg;
    logic               out_valid_reg;

    genvar gi, gj;

    // pp[i][j] carries weight i+j
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pp_row
            for (gj = 0; gj < WIDTH; gj++) begin : g_pp_col
                assign pp[gi][gj] = A[gj] & B[gi];
            end
        end
    endgenerate

    assign product[0] = pp[0][0];

    // Carry-save rows: cell (i,j) has weight i+j; its sum moves one column
    // right in the next row, its carry stays in the same column index.
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_csa_row
            for (gj = 0; gj < WIDTH - 1; gj++) begin : g_csa_col
                logic cell_a;
                logic cell_cin;
                if (gi == 1) begin : g_first
                    assign cell_a   = pp[0][gj+1];
                    assign cell_cin = 1'b0;
                end else begin : g_inner
                    if (gj < WIDTH - 2) begin : g_diag
                        assign cell_a = csa_sum[gi-1][gj+1];
                    end else begin : g_edge
                        assign cell_a = pp[gi-1][WIDTH-1];
                    end
                    assign cell_cin = csa_cry[gi-1][gj];
                end
                full_adder_cell u_fa (
                    .a    (cell_a),
                    .b    (pp[gi][gj]),
                    .cin  (cell_cin),
                    .sum  (csa_sum[gi][gj]),
                    .cout (csa_cry[gi][gj])
                );
            end
            assign product[gi] = csa_sum[gi][0];
        end
    endgenerate

    // Ripple row merges the last sums and carries into the upper product bits.
    assign rip_cry[0] = 1'b0;

    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_rip
            logic cell_a;
            if (gi < WIDTH - 2) begin : g_diag
                assign cell_a = csa_sum[WIDTH-1][gi+1];
            end else begin : g_edge
                assign cell_a = pp[WIDTH-1][WIDTH-1];
            end
            full_adder_cell u_fa (
                .a    (cell_a),
                .b    (csa_cry[WIDTH-1][gi]),
                .cin  (rip_cry[gi]),
                .sum  (product[WIDTH+gi]),
                .cout (rip_cry[gi+1])
            );
        end
    endgenerate

    assign product[2*WIDTH-1] = rip_cry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ab_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                ab_reg <= product;
            end
        end
    end

    assign AB        = ab_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_brauns_array_multiplier_4bit.sv
// Randomized and directed bench for the 4x4 Braun multiplier against an
// arithmetic reference model of the registered product.
module tb_brauns_array_multiplier_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       in_valid;
    logic [7:0] AB;
    logic       out_valid;

    int checks;
    int failures;

    logic [7:0] exp_ab;
    logic       exp_valid;

    brauns_array_multiplier_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .AB        (AB),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present inputs, clock once, then update the reference from plain arithmetic.
    task automatic apply(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        if (r) begin
            exp_ab    = 8'd0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) exp_ab = 8'(int'(a) * int'(b));
        end
        $display("txn rst=%0d in_valid=%0d A=%0d B=%0d -> AB=%0d out_valid=%0d", r, v, a, b, AB, out_valid);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 4'd15, 4'd15);
            checks++;
            if (AB !== 8'd0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: AB=%0d out_valid=%0d required AB=0 out_valid=0", AB, out_valid);
            end
        end
        apply(1'b0, 1'b1, 4'd15, 4'd15);
        checks++;
        if (AB !== 8'd225 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: AB=%0d out_valid=%0d required AB=225 out_valid=1", AB, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [3:0] da [4] = '{4'd3, 4'd12, 4'd3, 4'd13};
        logic [3:0] db [4] = '{4'd10, 4'd10, 4'd11, 4'd10};
        logic [7:0] dp [4] = '{8'd30, 8'd120, 8'd33, 8'd130};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, da[i], db[i]);
            checks++;
            if (AB !== dp[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL directed_%0d: AB=%0d out_valid=%0d required AB=%0d out_valid=1", i, AB, out_valid, dp[i]);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 4'd7, 4'd7);
            checks++;
            if (AB !== 8'd130 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: AB=%0d out_valid=%0d required AB=130 out_valid=0", i, AB, out_valid);
            end
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 4'bxxxx, 4'bzzzz);
            checks++;
            if (AB !== 8'd130 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_xz_%0d: AB=%0d out_valid=%0d required AB=130 out_valid=0", i, AB, out_valid);
            end
        end
    endtask

    task automatic test_extremes();
        logic [3:0] ea [5] = '{4'd15, 4'd0, 4'd8, 4'd1, 4'd15};
        logic [3:0] eb [5] = '{4'd15, 4'd0, 4'd8, 4'd15, 4'd1};
        logic [7:0] ep [5] = '{8'd225, 8'd0, 8'd64, 8'd15, 8'd15};
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, ea[i], eb[i]);
            checks++;
            if (AB !== ep[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL extreme_%0dx%0d: AB=%0d out_valid=%0d required AB=%0d out_valid=1", ea[i], eb[i], AB, out_valid, ep[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int valid_run = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                apply(1'b0, 1'b1, 4'(a), 4'(b));
                checks++;
                if (AB !== 8'(a * b)) begin
                    failures++;
                    $display("FAIL exhaustive_%0dx%0d: AB=%0d required %0d", a, b, AB, a * b);
                end
                if (out_valid === 1'b1) valid_run++;
            end
        end
        checks++;
        if (valid_run != 256) begin
            failures++;
            $display("FAIL exhaustive_valid_run: out_valid high on %0d cycles required 256", valid_run);
        end
    endtask

    task automatic test_reset_midstream();
        apply(1'b0, 1'b1, 4'd12, 4'd10);
        apply(1'b1, 1'b1, 4'd5, 4'd5);
        checks++;
        if (AB !== 8'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_drop: AB=%0d out_valid=%0d required AB=0 out_valid=0", AB, out_valid);
        end
        apply(1'b0, 1'b1, 4'd3, 4'd11);
        checks++;
        if (AB !== 8'd33 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_resume: AB=%0d out_valid=%0d required AB=33 out_valid=1", AB, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            checks++;
            if (AB !== exp_ab || out_valid !== exp_valid) begin
                failures++;
                $display("FAIL random_%0d: AB=%0d out_valid=%0d required AB=%0d out_valid=%0d", i, AB, out_valid, exp_ab, exp_valid);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_ab    = 8'd0;
        exp_valid = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = 4'd0;
        B         = 4'd0;
        test_reset();
        test_directed();
        test_hold();
        test_extremes();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
